// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between instruction fetch and
//               data memory ports, with anti-starvation and response timeout.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              arst_n,
    // instruction fetch port
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    output logic              stall_if_o,
    // data memory port
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              stall_mem_o,
    // memory side
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    localparam int C_SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int C_TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [C_SW-1:0] C_STARVE_MAX = C_SW'(STARVE_MAX);
    localparam logic [C_TW-1:0] C_TMO_LAST   = C_TW'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic              r_owner;     // 1 = DM owns the access, 0 = IF
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [C_SW-1:0]   r_starve;
    logic [C_TW-1:0]   r_tcnt;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_err;

    logic w_if_wins;
    logic w_tmo;
    logic w_in_req;
    logic w_done;

    // IF wins when DM is idle or when DM has already beaten it STARVE_MAX times in a row
    assign w_if_wins = if_req_i & (~dm_req_i | (r_starve == C_STARVE_MAX));
    assign w_tmo     = (r_tcnt == C_TMO_LAST);
    assign w_in_req  = (r_state == S_REQ);
    assign w_done    = (r_state == S_DONE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_starve   <= '0;
            r_tcnt     <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!if_req_i) begin
                        r_starve <= '0;
                    end
                    if (if_req_i || dm_req_i) begin
                        r_state <= S_REQ;
                        if (w_if_wins) begin
                            r_owner  <= 1'b0;
                            r_we     <= 1'b0;
                            r_addr   <= if_addr_i;
                            r_wdata  <= '0;
                            r_starve <= '0;
                        end else begin
                            r_owner <= 1'b1;
                            r_we    <= dm_we_i;
                            r_addr  <= dm_addr_i;
                            r_wdata <= dm_wdata_i;
                            if (if_req_i && (r_starve != C_STARVE_MAX)) begin
                                r_starve <= r_starve + 1'b1;
                            end
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        r_state <= S_RESP;
                        r_tcnt  <= '0;
                    end
                end
                S_RESP: begin
                    if (mem_rvalid_i || w_tmo) begin
                        r_state <= S_DONE;
                        if (!mem_rvalid_i) begin
                            r_err <= 1'b1;
                        end
                        // stores and timed-out accesses report zero data
                        if (r_owner) begin
                            r_dm_rdata <= (mem_rvalid_i && !r_we) ? mem_rdata_i : '0;
                        end else begin
                            r_if_rdata <= mem_rvalid_i ? mem_rdata_i : '0;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = w_in_req;
    assign mem_we_o    = w_in_req & r_we;
    assign mem_addr_o  = w_in_req ? r_addr  : '0;
    assign mem_wdata_o = w_in_req ? r_wdata : '0;

    assign if_valid_o  = w_done & ~r_owner;
    assign dm_valid_o  = w_done &  r_owner;
    assign if_rdata_o  = r_if_rdata;
    assign dm_rdata_o  = r_dm_rdata;
    assign stall_if_o  = if_req_i & ~if_valid_o;
    assign stall_mem_o = dm_req_i & ~dm_valid_o;
    assign err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed scoreboard bench for mem_port_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk;
    logic        arst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        stall_if_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_valid_o;
    logic        stall_mem_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(2),
        .TIMEOUT   (16)
    ) u_dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_valid_o  (if_valid_o),
        .stall_if_o  (stall_if_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_valid_o  (dm_valid_o),
        .stall_mem_o (stall_mem_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .err_o       (err_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } mem_t;

    typedef struct {
        bit          dm;
        logic [31:0] data;
    } comp_t;

    mem_t  mem_q[$];
    comp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int gnt_delay = 0;
    bit rv_never  = 0;
    bit rv_in_req = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    function automatic void push_access(input bit dm, input logic we, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [31:0] mem_rd,
                                        input logic [31:0] exp_rd);
        mem_t  m;
        comp_t c;
        m.we = we; m.addr = addr; m.wdata = wdata; m.rdata = mem_rd;
        c.dm = dm; c.data = exp_rd;
        mem_q.push_back(m);
        exp_q.push_back(c);
    endfunction

    // memory model: checks request fields every REQ cycle, then grants and responds
    initial begin
        mem_t m;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(posedge clk); #1;
            if (arst_n && mem_req_o) begin
                if (mem_q.size() == 0) begin
                    chk("mem_unexpected_req", {1'b1, mem_addr_o}, {1'b0, 32'h0});
                    mem_gnt_i = 1'b1;
                    @(posedge clk); #1;
                    mem_gnt_i = 1'b0;
                end else begin
                    m = mem_q.pop_front();
                    for (int k = 0; k <= gnt_delay; k++) begin
                        chk("mem_req_fields", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o},
                            {1'b1, m.we, m.addr, m.wdata});
                        if (k == gnt_delay) mem_gnt_i = 1'b1;
                        if (k == 0 && rv_in_req) begin
                            mem_rvalid_i = 1'b1;
                            mem_rdata_i  = 32'hBAD0_BAD0;
                        end
                        @(posedge clk); #1;
                        mem_rvalid_i = 1'b0;
                    end
                    mem_gnt_i = 1'b0;
                    if (!rv_never) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i  = m.rdata;
                        @(posedge clk); #1;
                        mem_rvalid_i = 1'b0;
                        mem_rdata_i  = '0;
                    end
                end
            end
        end
    end

    // completion monitor
    initial begin
        comp_t e;
        forever begin
            @(posedge clk); #1;
            if (arst_n && (if_valid_o || dm_valid_o)) begin
                if (if_valid_o && dm_valid_o) begin
                    chk("comp_both_valid", 2'b11, 2'b01);
                end else if (exp_q.size() == 0) begin
                    chk("comp_unexpected", {dm_valid_o, if_valid_o}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("comp_port", dm_valid_o, e.dm);
                    chk("comp_rdata", dm_valid_o ? dm_rdata_o : if_rdata_o, e.data);
                end
            end
        end
    end

    // waits for one port's completion; stall_mode checks stall_if_o along the way
    task automatic wait_done(input bit dm, input bit stall_mode, input string name, output int lat);
        int  t0;
        bit  got;
        t0  = cyc;
        got = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (dm ? dm_valid_o : if_valid_o) begin
                got = 1'b1;
                break;
            end
            if (stall_mode) chk({name, "_stall_if_wait"}, stall_if_o, 1'b1);
        end
        lat = cyc - t0;
        if (!got) tmo(name);
        else if (stall_mode) chk({name, "_stall_if_done"}, stall_if_o, dm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          dm_i;
        int          if_i;
        bit          got;
        bit          to;
        logic [31:0] dm_addrs[4];
        logic [31:0] if_addrs[2];

        dm_addrs = '{32'h10, 32'h14, 32'h18, 32'h1C};
        if_addrs = '{32'h300, 32'h304};

        arst_n     = 1'b0;
        if_req_i   = 1'b0;
        if_addr_i  = '0;
        dm_req_i   = 1'b0;
        dm_we_i    = 1'b0;
        dm_addr_i  = '0;
        dm_wdata_i = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {if_rdata_o, if_valid_o, stall_if_o, dm_rdata_o, dm_valid_o, stall_mem_o,
                              mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o}, '0);
        arst_n = 1'b1;
        @(posedge clk); #1;

        // 1: lone IF read
        push_access(0, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        #1;
        chk("s1_stall_if_c0", stall_if_o, 1'b1);
        wait_done(0, 1, "s1", lat);
        chk("s1_latency", lat, 3);
        if_req_i = 1'b0;
        @(posedge clk); #1;

        // 2: simultaneous IF load and DM store, DM first
        push_access(1, 1, 32'h40, 32'h1234_5678, 32'hAAAA_5555, 32'h0);
        push_access(0, 0, 32'h200, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D);
        if_req_i   = 1'b1;
        if_addr_i  = 32'h200;
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b1;
        dm_addr_i  = 32'h40;
        dm_wdata_i = 32'h1234_5678;
        #1;
        chk("s2_stall_mem_c0", stall_mem_o, 1'b1);
        wait_done(1, 1, "s2_dm", lat);
        chk("s2_dm_latency", lat, 3);
        dm_req_i   = 1'b0;
        dm_we_i    = 1'b0;
        dm_wdata_i = '0;
        wait_done(0, 0, "s2_if", lat);
        chk("s2_if_latency", lat, 4);
        chk("s2_dm_rdata_hold", dm_rdata_o, 32'h0);
        if_req_i = 1'b0;
        @(posedge clk); #1;

        // 3: starvation guard with STARVE_MAX=2
        push_access(1, 0, 32'h10, 32'h0, 32'hD000_0010, 32'hD000_0010);
        push_access(1, 0, 32'h14, 32'h0, 32'hD000_0014, 32'hD000_0014);
        push_access(0, 0, 32'h300, 32'h0, 32'h1F00_0300, 32'h1F00_0300);
        push_access(1, 0, 32'h18, 32'h0, 32'hD000_0018, 32'hD000_0018);
        push_access(1, 0, 32'h1C, 32'h0, 32'hD000_001C, 32'hD000_001C);
        push_access(0, 0, 32'h304, 32'h0, 32'h1F00_0304, 32'h1F00_0304);
        dm_i      = 0;
        if_i      = 0;
        to        = 1'b0;
        if_req_i  = 1'b1;
        if_addr_i = if_addrs[0];
        dm_req_i  = 1'b1;
        dm_addr_i = dm_addrs[0];
        for (int k = 0; k < 6 && !to; k++) begin
            got = 1'b0;
            for (int c = 0; c < 60; c++) begin
                @(posedge clk); #1;
                if (if_valid_o || dm_valid_o) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                tmo("s3_completion");
                to = 1'b1;
            end else begin
                if (dm_valid_o) begin
                    chk("s3_if_rdata_hold", if_rdata_o, (if_i == 0) ? 32'hCAFE_F00D : 32'h1F00_0300);
                    dm_i++;
                    if (dm_i < 4) dm_addr_i = dm_addrs[dm_i];
                    else dm_req_i = 1'b0;
                end
                if (if_valid_o) begin
                    if_i++;
                    if (if_i < 2) if_addr_i = if_addrs[if_i];
                    else if_req_i = 1'b0;
                end
            end
        end
        dm_req_i = 1'b0;
        if_req_i = 1'b0;
        @(posedge clk); #1;

        // 4: DM load timeout, then a good IF access with err_o still set
        chk("s4_err_before", err_o, 1'b0);
        rv_never = 1'b1;
        push_access(1, 0, 32'h80, 32'h0, 32'h0, 32'h0);
        dm_req_i  = 1'b1;
        dm_addr_i = 32'h80;
        wait_done(1, 0, "s4_dm", lat);
        chk("s4_tmo_latency", lat, 18);
        rv_never = 1'b0;
        dm_req_i = 1'b0;
        @(posedge clk); #1;
        chk("s4_err_set", err_o, 1'b1);
        push_access(0, 0, 32'h104, 32'h0, 32'h1111_2222, 32'h1111_2222);
        if_req_i  = 1'b1;
        if_addr_i = 32'h104;
        wait_done(0, 0, "s4_if", lat);
        chk("s4_if_latency", lat, 3);
        chk("s4_err_sticky", err_o, 1'b1);
        if_req_i = 1'b0;
        @(posedge clk); #1;

        // 5: grant withheld 3 cycles, stray rvalid during REQ
        gnt_delay = 3;
        rv_in_req = 1'b1;
        push_access(1, 1, 32'h44, 32'hA5A5_A5A5, 32'h7777_7777, 32'h0);
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b1;
        dm_addr_i  = 32'h44;
        dm_wdata_i = 32'hA5A5_A5A5;
        wait_done(1, 0, "s5_dm", lat);
        chk("s5_latency", lat, 6);
        gnt_delay  = 0;
        rv_in_req  = 1'b0;
        dm_req_i   = 1'b0;
        dm_we_i    = 1'b0;
        dm_wdata_i = '0;
        @(posedge clk); #1;

        // 6: asynchronous reset during RESP, then a fresh IF read
        rv_never = 1'b1;
        mem_q.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h0, rdata: 32'h0});
        if_req_i  = 1'b1;
        if_addr_i = 32'h500;
        @(posedge clk); #1;
        @(posedge clk); #2;
        arst_n   = 1'b0;
        if_req_i = 1'b0;
        #1;
        chk("s6_async_reset", {if_rdata_o, if_valid_o, stall_if_o, dm_rdata_o, dm_valid_o, stall_mem_o,
                               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o}, '0);
        rv_never = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(posedge clk); #1;
        push_access(0, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        #1;
        wait_done(0, 1, "s6_if", lat);
        chk("s6_latency", lat, 3);
        if_req_i = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        chk("end_exp_q_empty", exp_q.size(), 0);
        chk("end_mem_q_empty", mem_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
